id_stage: RTL and testbench

- Instruction-decode stage of the RV32I 5-stage pipeline. Sits between fetch and the ID/EX pipeline register.
- Contains:
  - the IF/ID latch;
  - a 32x32 register file with write-through bypass;
  - the main decoder and immediate generator;
  - load-use hazard detection.
- Its outputs are the `_in` side of the ID/EX register. It consumes that register's rd/mem-read feedback and the WB-stage write port.

---
 rtl/id_stage_if.sv | 49 ++++
 rtl/id_stage.sv | 197 +++++++++++++++++++
 tb/tb_id_stage.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/id_stage_if.sv
// Fetch, hazard-feedback, WB write port and decoded-output bundle of the decode stage.
// master = decode stage, slave = surrounding pipeline.
interface id_stage_if;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        flush;
  logic        idex_mem_read;
  logic [4:0]  idex_rd;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic        stall;
  logic [31:0] pc_out;
  logic [31:0] pc4_out;
  logic [31:0] operand1_out;
  logic [31:0] operand2_out;
  logic [31:0] imm_out;
  logic [4:0]  rs1_out;
  logic [4:0]  rs2_out;
  logic [4:0]  rd_out;
  logic [3:0]  alu_fun_out;
  logic        op1_sel_out;
  logic        op2_sel_out;
  logic [1:0]  wb_sel_out;
  logic        reg_we_out;
  logic        mem_rw_out;
  logic        mem_read_out;
  logic [2:0]  mem_val_out;
  logic        branch_out;
  logic        jump_out;
  logic        illegal_out;

  modport master (
    input  if_instr, if_pc, flush, idex_mem_read, idex_rd, wb_we, wb_rd, wb_data,
    output stall, pc_out, pc4_out, operand1_out, operand2_out, imm_out,
           rs1_out, rs2_out, rd_out, alu_fun_out, op1_sel_out, op2_sel_out,
           wb_sel_out, reg_we_out, mem_rw_out, mem_read_out, mem_val_out,
           branch_out, jump_out, illegal_out
  );

  modport slave (
    output if_instr, if_pc, flush, idex_mem_read, idex_rd, wb_we, wb_rd, wb_data,
    input  stall, pc_out, pc4_out, operand1_out, operand2_out, imm_out,
           rs1_out, rs2_out, rd_out, alu_fun_out, op1_sel_out, op2_sel_out,
           wb_sel_out, reg_we_out, mem_rw_out, mem_read_out, mem_val_out,
           branch_out, jump_out, illegal_out
  );
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: IF/ID latch, bypassed register file, decoder, load-use detect.
// Outputs are combinational 1 cycle after fetch; stall holds IF/ID and bubbles ID/EX.
module id_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input logic        clk,
  input logic        rst,
  id_stage_if.master bus
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic        legal, uses_rs1, uses_rs2, we_raw, mem_rw_raw, mem_rd_raw, br_raw, jmp_raw;
  logic        stall, bubble;
  logic [31:0] imm;
  logic [3:0]  alu_fun;
  logic        op1_sel, op2_sel;
  logic [1:0]  wb_sel;
  logic        wb_hit;

  assign opcode = id_instr_q[6:0];
  assign rd     = id_instr_q[11:7];
  assign funct3 = id_instr_q[14:12];
  assign rs1    = id_instr_q[19:15];
  assign rs2    = id_instr_q[24:20];

  always_comb begin
    legal      = 1'b1;
    uses_rs1   = 1'b0;
    uses_rs2   = 1'b0;
    we_raw     = 1'b0;
    mem_rw_raw = 1'b0;
    mem_rd_raw = 1'b0;
    br_raw     = 1'b0;
    jmp_raw    = 1'b0;
    imm        = 32'h0;
    alu_fun    = 4'b0000;
    op1_sel    = 1'b0;
    op2_sel    = 1'b0;
    wb_sel     = 2'b00;
    case (opcode)
      OPC_LUI: begin
        imm = {id_instr_q[31:12], 12'h000};
        alu_fun = 4'b1111;
        op2_sel = 1'b1;
        we_raw = 1'b1;
      end
      OPC_AUIPC: begin
        imm = {id_instr_q[31:12], 12'h000};
        op1_sel = 1'b1;
        op2_sel = 1'b1;
        we_raw = 1'b1;
      end
      OPC_JAL: begin
        imm = {{11{id_instr_q[31]}}, id_instr_q[31], id_instr_q[19:12],
               id_instr_q[20], id_instr_q[30:21], 1'b0};
        op1_sel = 1'b1;
        op2_sel = 1'b1;
        wb_sel = 2'b10;
        we_raw = 1'b1;
        jmp_raw = 1'b1;
      end
      OPC_JALR: begin
        imm = {{20{id_instr_q[31]}}, id_instr_q[31:20]};
        uses_rs1 = 1'b1;
        op2_sel = 1'b1;
        wb_sel = 2'b10;
        we_raw = 1'b1;
        jmp_raw = 1'b1;
      end
      OPC_BRANCH: begin
        imm = {{19{id_instr_q[31]}}, id_instr_q[31], id_instr_q[7],
               id_instr_q[30:25], id_instr_q[11:8], 1'b0};
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        br_raw = 1'b1;
      end
      OPC_LOAD: begin
        imm = {{20{id_instr_q[31]}}, id_instr_q[31:20]};
        uses_rs1 = 1'b1;
        op2_sel = 1'b1;
        wb_sel = 2'b01;
        we_raw = 1'b1;
        mem_rd_raw = 1'b1;
      end
      OPC_STORE: begin
        imm = {{20{id_instr_q[31]}}, id_instr_q[31:25], id_instr_q[11:7]};
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        op2_sel = 1'b1;
        mem_rw_raw = 1'b1;
      end
      OPC_OPIMM: begin
        imm = {{20{id_instr_q[31]}}, id_instr_q[31:20]};
        uses_rs1 = 1'b1;
        op2_sel = 1'b1;
        we_raw = 1'b1;
        // Only SRAI carries funct7[5] into the ALU op; other I-type imms reuse those bits.
        alu_fun = (funct3 == 3'b101 && id_instr_q[30]) ? 4'b1101 : {1'b0, funct3};
      end
      OPC_OP: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        we_raw = 1'b1;
        alu_fun = {id_instr_q[30], funct3};
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    stall = id_valid_q & bus.idex_mem_read & (bus.idex_rd != 5'd0)
          & (((bus.idex_rd == rs1) & uses_rs1) | ((bus.idex_rd == rs2) & uses_rs2))
          & ~bus.flush;
    bubble = stall | bus.flush | ~id_valid_q | ~legal;
  end

  always_comb begin
    id_instr_d = bus.if_instr;
    id_pc_d    = bus.if_pc;
    id_valid_d = 1'b1;
    if (bus.flush) begin
      id_instr_d = NOP_INSTR;
      id_pc_d    = RESET_PC;
      id_valid_d = 1'b0;
    end else if (stall) begin
      id_instr_d = id_instr_q;
      id_pc_d    = id_pc_q;
      id_valid_d = id_valid_q;
    end
  end

  // Writes to x0 are never stored, so rf_q[0] stays zero from reset onward.
  always_comb begin
    rf_d = rf_q;
    if (bus.wb_we && bus.wb_rd != 5'd0) rf_d[bus.wb_rd] = bus.wb_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_instr_q <= NOP_INSTR;
      id_pc_q    <= RESET_PC;
      id_valid_q <= 1'b0;
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'h0;
    end else begin
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      id_valid_q <= id_valid_d;
      rf_q       <= rf_d;
    end
  end

  assign wb_hit = bus.wb_we & (bus.wb_rd != 5'd0) & ~rst;

  always_comb begin
    bus.operand1_out = (wb_hit && bus.wb_rd == rs1) ? bus.wb_data : rf_q[rs1];
    bus.operand2_out = (wb_hit && bus.wb_rd == rs2) ? bus.wb_data : rf_q[rs2];
  end

  assign bus.stall        = stall;
  assign bus.pc_out       = id_pc_q;
  assign bus.pc4_out      = id_pc_q + 32'd4;
  assign bus.imm_out      = imm;
  assign bus.rs1_out      = rs1;
  assign bus.rs2_out      = rs2;
  assign bus.rd_out       = rd;
  assign bus.alu_fun_out  = alu_fun;
  assign bus.op1_sel_out  = op1_sel;
  assign bus.op2_sel_out  = op2_sel;
  assign bus.wb_sel_out   = wb_sel;
  assign bus.mem_val_out  = funct3;
  assign bus.reg_we_out   = we_raw & (rd != 5'd0) & ~bubble;
  assign bus.mem_rw_out   = mem_rw_raw & ~bubble;
  assign bus.mem_read_out = mem_rd_raw & ~bubble;
  assign bus.branch_out   = br_raw & ~bubble;
  assign bus.jump_out     = jmp_raw & ~bubble;
  assign bus.illegal_out  = id_valid_q & ~legal & ~bus.flush;

endmodule

// File: tb/tb_id_stage.sv
// Directed checks of the decode stage: reset, decode, bypass, load-use, flush, immediates.
module tb_id_stage;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  id_stage_if bus ();

  id_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_instr(input logic [31:0] instr, input logic [31:0] pc);
    bus.if_instr = instr;
    bus.if_pc    = pc;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.if_instr = 32'h0; bus.if_pc = 32'h0; bus.flush = 1'b0;
    bus.idex_mem_read = 1'b0; bus.idex_rd = 5'd0;
    bus.wb_we = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 32'h0;

    tick();
    tick();
    chk("rst_stall", {31'h0, bus.stall}, 32'h0);
    chk("rst_pc", bus.pc_out, 32'h0);
    chk("rst_pc4", bus.pc4_out, 32'h4);
    chk("rst_op1", bus.operand1_out, 32'h0);
    chk("rst_op2", bus.operand2_out, 32'h0);
    chk("rst_imm", bus.imm_out, 32'h0);
    chk("rst_we", {31'h0, bus.reg_we_out}, 32'h0);
    chk("rst_illegal", {31'h0, bus.illegal_out}, 32'h0);

    // addi x1,x0,5
    rst = 1'b0;
    load_instr(32'h0050_0093, 32'h100);
    chk("addi_imm", bus.imm_out, 32'd5);
    chk("addi_rd", {27'h0, bus.rd_out}, 32'd1);
    chk("addi_we", {31'h0, bus.reg_we_out}, 32'h1);
    chk("addi_op2sel", {31'h0, bus.op2_sel_out}, 32'h1);
    chk("addi_pc", bus.pc_out, 32'h100);
    chk("addi_pc4", bus.pc4_out, 32'h104);
    chk("addi_alu", {28'h0, bus.alu_fun_out}, 32'h0);

    // add x3,x2,x0 with WB writing x2 in the same cycle
    load_instr(32'h0001_01B3, 32'h104);
    bus.wb_we = 1'b1; bus.wb_rd = 5'd2; bus.wb_data = 32'hDEAD_BEEF;
    #1;
    chk("byp_op1", bus.operand1_out, 32'hDEAD_BEEF);
    chk("byp_op2", bus.operand2_out, 32'h0);
    chk("byp_rs1", {27'h0, bus.rs1_out}, 32'd2);
    chk("byp_wbsel", {30'h0, bus.wb_sel_out}, 32'h0);
    tick();
    bus.wb_rd = 5'd0; bus.wb_data = 32'h1234_5678;
    #1;
    chk("x2_stored", bus.operand1_out, 32'hDEAD_BEEF);
    chk("x0_nobyp", bus.operand2_out, 32'h0);
    tick();
    bus.wb_we = 1'b0;
    #1;
    chk("x0_nowrite", bus.operand2_out, 32'h0);

    // add x6,x5,x7 behind a load of x5
    load_instr(32'h0072_8333, 32'h108);
    bus.idex_mem_read = 1'b1; bus.idex_rd = 5'd5;
    bus.if_instr = 32'h0050_0093; bus.if_pc = 32'h10C;
    #1;
    chk("lu_stall", {31'h0, bus.stall}, 32'h1);
    chk("lu_we", {31'h0, bus.reg_we_out}, 32'h0);
    tick();
    chk("lu_hold_pc", bus.pc_out, 32'h108);
    chk("lu_hold_stall", {31'h0, bus.stall}, 32'h1);
    bus.idex_mem_read = 1'b0;
    bus.wb_we = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'h0000_0055;
    #1;
    chk("lu_release", {31'h0, bus.stall}, 32'h0);
    chk("lu_byp_op1", bus.operand1_out, 32'h55);
    chk("lu_we_back", {31'h0, bus.reg_we_out}, 32'h1);
    tick();
    bus.wb_we = 1'b0;
    chk("lu_advance_pc", bus.pc_out, 32'h10C);

    load_instr(32'h0072_8333, 32'h110);
    bus.idex_mem_read = 1'b1; bus.idex_rd = 5'd0;
    #1;
    chk("lu_rd0_stall", {31'h0, bus.stall}, 32'h0);
    chk("x5_stored", bus.operand1_out, 32'h55);
    bus.idex_rd = 5'd7;
    #1;
    chk("lu_rs2_stall", {31'h0, bus.stall}, 32'h1);

    // flush overrides the load-use stall
    bus.flush = 1'b1;
    #1;
    chk("fl_stall", {31'h0, bus.stall}, 32'h0);
    chk("fl_we", {31'h0, bus.reg_we_out}, 32'h0);
    tick();
    bus.flush = 1'b0; bus.idex_mem_read = 1'b0; bus.idex_rd = 5'd0;
    #1;
    chk("fl_pc", bus.pc_out, 32'h0);
    chk("fl_rd", {27'h0, bus.rd_out}, 32'h0);
    chk("fl_imm", bus.imm_out, 32'h0);
    chk("fl_we_nop", {31'h0, bus.reg_we_out}, 32'h0);
    chk("fl_illegal", {31'h0, bus.illegal_out}, 32'h0);

    // beq x0,x0,-4
    load_instr(32'hFE00_0EE3, 32'h200);
    chk("b_imm", bus.imm_out, 32'hFFFF_FFFC);
    chk("b_branch", {31'h0, bus.branch_out}, 32'h1);
    chk("b_we", {31'h0, bus.reg_we_out}, 32'h0);

    // jal x1, -1MiB
    load_instr(32'h8000_00EF, 32'h204);
    chk("j_imm", bus.imm_out, 32'hFFF0_0000);
    chk("j_jump", {31'h0, bus.jump_out}, 32'h1);
    chk("j_wbsel", {30'h0, bus.wb_sel_out}, 32'h2);
    chk("j_op1sel", {31'h0, bus.op1_sel_out}, 32'h1);

    // sw x1,12(x2)
    load_instr(32'h0011_2623, 32'h208);
    chk("s_imm", bus.imm_out, 32'd12);
    chk("s_memrw", {31'h0, bus.mem_rw_out}, 32'h1);
    chk("s_we", {31'h0, bus.reg_we_out}, 32'h0);
    chk("s_memval", {29'h0, bus.mem_val_out}, 32'h2);
    chk("s_rs2", {27'h0, bus.rs2_out}, 32'd1);

    // lw x5,0(x1)
    load_instr(32'h0000_A283, 32'h20C);
    chk("l_memread", {31'h0, bus.mem_read_out}, 32'h1);
    chk("l_wbsel", {30'h0, bus.wb_sel_out}, 32'h1);

    // lui x1,0x12345
    load_instr(32'h1234_50B7, 32'h210);
    chk("lui_imm", bus.imm_out, 32'h1234_5000);
    chk("lui_alu", {28'h0, bus.alu_fun_out}, 32'hF);

    // srai x1,x1,1
    load_instr(32'h4010_D093, 32'h214);
    chk("srai_alu", {28'h0, bus.alu_fun_out}, 32'hD);

    // unrecognised opcode at the top of the address space
    load_instr(32'h0000_007F, 32'hFFFF_FFFC);
    chk("ill_flag", {31'h0, bus.illegal_out}, 32'h1);
    chk("ill_en", {27'h0, bus.reg_we_out, bus.mem_rw_out, bus.mem_read_out,
                   bus.branch_out, bus.jump_out}, 32'h0);
    chk("ill_pc4_wrap", bus.pc4_out, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
